// File: rtl/fast_square_energy_if.sv
// Sample/energy bundle between a source and fast_square_energy.
// FAST_SQR_LANE_OUT_EN adds the per-lane square outputs.
interface fast_square_energy_if #(
    parameter int WIDTH   = 9,
    parameter int LANES   = 4,
    parameter int LOG_WIN = 4
);
    logic                     i_valid;
    logic [LANES*WIDTH-1:0]   i_data;
    logic                     i_clear;
`ifdef FAST_SQR_LANE_OUT_EN
    logic [LANES*(2*WIDTH-1)-1:0] o_sqr;
    logic                         o_sqr_valid;
`endif
    logic [2*WIDTH-1+$clog2(LANES)+LOG_WIN-1:0] o_energy;
    logic                                       o_energy_valid;

`ifdef FAST_SQR_LANE_OUT_EN
    modport master (
        output i_valid, i_data, i_clear,
        input  o_sqr, o_sqr_valid, o_energy, o_energy_valid
    );
    modport slave (
        input  i_valid, i_data, i_clear,
        output o_sqr, o_sqr_valid, o_energy, o_energy_valid
    );
`else
    modport master (
        output i_valid, i_data, i_clear,
        input  o_energy, o_energy_valid
    );
    modport slave (
        input  i_valid, i_data, i_clear,
        output o_energy, o_energy_valid
    );
`endif
endinterface

// File: rtl/fast_square_energy.sv
// Four-stage windowed sum-of-squares over LANES signed samples per beat.
// Macro FAST_SQR_LANE_OUT_EN exposes the per-lane squares from S2.
module fast_square_energy #(
    parameter int WIDTH   = 9,
    parameter int LANES   = 4,
    parameter int LOG_WIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    fast_square_energy_if.slave bus
);
    localparam int SQ_W  = 2 * WIDTH - 1;
    localparam int SUM_W = SQ_W + $clog2(LANES);
    localparam int EN_W  = SUM_W + LOG_WIN;
    localparam int CNT_W = (LOG_WIN > 0) ? LOG_WIN : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG_WIN) - 1);

    logic                   s1_valid_q, s1_valid_d;
    logic [LANES*WIDTH-1:0] s1_data_q, s1_data_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*SQ_W-1:0]  s2_sqr_q, s2_sqr_d;
    logic                   s3_valid_q, s3_valid_d;
    logic [SUM_W-1:0]       s3_sum_q, s3_sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [EN_W-1:0]        acc_q, acc_d;
    logic [EN_W-1:0]        energy_q, energy_d;
    logic                   energy_valid_q, energy_valid_d;

    logic signed [SQ_W-1:0] lane_x;
    logic [SQ_W-1:0]        lane_sq;
    logic [EN_W-1:0]        acc_sum;

    // S1 capture and S2 exact squares; sign-extending first keeps -2**(W-1) exact
    always_comb begin
        s1_valid_d = bus.i_valid;
        s1_data_d  = bus.i_data;
        s2_valid_d = s1_valid_q & ~bus.i_clear;
        s2_sqr_d   = '0;
        lane_x     = '0;
        lane_sq    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_x  = SQ_W'($signed(s1_data_q[k*WIDTH +: WIDTH]));
            lane_sq = lane_x * lane_x;
            s2_sqr_d[k*SQ_W +: SQ_W] = lane_sq;
        end
    end

    // S3 lane sum; clear drops whatever sits in S2
    always_comb begin
        s3_valid_d = s2_valid_q & ~bus.i_clear;
        s3_sum_d   = '0;
        for (int k = 0; k < LANES; k++) begin
            s3_sum_d = s3_sum_d + SUM_W'(s2_sqr_q[k*SQ_W +: SQ_W]);
        end
    end

    // S4 window accumulator; clear restarts the window and kills the S3 beat
    always_comb begin
        acc_sum        = acc_q + EN_W'(s3_sum_q);
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        energy_d       = energy_q;
        energy_valid_d = 1'b0;
        if (bus.i_clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (s3_valid_q) begin
            if (cnt_q == LAST) begin
                energy_d       = acc_sum;
                energy_valid_d = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_sqr_q       <= '0;
            s3_valid_q     <= 1'b0;
            s3_sum_q       <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s2_valid_q     <= s2_valid_d;
            s2_sqr_q       <= s2_sqr_d;
            s3_valid_q     <= s3_valid_d;
            s3_sum_q       <= s3_sum_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            energy_q       <= energy_d;
            energy_valid_q <= energy_valid_d;
        end
    end

    assign bus.o_energy       = energy_q;
    assign bus.o_energy_valid = energy_valid_q;
`ifdef FAST_SQR_LANE_OUT_EN
    assign bus.o_sqr       = s2_sqr_q;
    assign bus.o_sqr_valid = s2_valid_q;
`endif
endmodule

// File: tb/tb_fast_square_energy.sv
// Scoreboard bench for fast_square_energy (default and LOG_WIN=0 builds).
// Define FAST_SQR_LANE_OUT_EN to also score the per-lane squares.
module tb_fast_square_energy;
    localparam int W     = 9;
    localparam int L     = 4;
    localparam int LW    = 4;
    localparam int SQ_W  = 2 * W - 1;
    localparam int EN_W  = SQ_W + 2 + LW;
    localparam int EN2_W = SQ_W + 2;
    localparam int WIN   = 1 << LW;

    typedef struct {
        longint val;
        int     due;
    } exp_t;
    typedef struct {
        logic [L*SQ_W-1:0] val;
        int                due;
    } sq_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    exp_t eq[$];
    sq_t  sq[$];
    exp_t e;
    sq_t  s;
    longint hold;
    int     mcnt;
    longint macc;

    fast_square_energy_if #(.WIDTH(W), .LANES(L), .LOG_WIN(LW)) bus ();
    fast_square_energy_if #(.WIDTH(W), .LANES(L), .LOG_WIN(0)) bus2 ();

    fast_square_energy #(.WIDTH(W), .LANES(L), .LOG_WIN(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fast_square_energy #(.WIDTH(W), .LANES(L), .LOG_WIN(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (eq.size() != 0 && eq[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL energy_missed cyc=%0d required pulse %0d at cyc %0d",
                     cyc, eq[0].val, eq[0].due);
            void'(eq.pop_front());
        end
        if (bus.o_energy_valid === 1'b1) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL energy_unexpected cyc=%0d got %0d required no pulse",
                         cyc, bus.o_energy);
            end else begin
                e = eq.pop_front();
                if (bus.o_energy !== EN_W'(e.val) || cyc != e.due) begin
                    errors++;
                    $display("FAIL energy_pulse got %0d at cyc %0d required %0d at cyc %0d",
                             bus.o_energy, cyc, e.val, e.due);
                end
                hold = e.val;
            end
        end else if (rst) begin
            hold = 0;
        end else begin
            checks++;
            if (bus.o_energy_valid !== 1'b0 || bus.o_energy !== EN_W'(hold)) begin
                errors++;
                $display("FAIL energy_hold cyc=%0d got %0d/v%b required %0d/v0",
                         cyc, bus.o_energy, bus.o_energy_valid, hold);
            end
        end
`ifdef FAST_SQR_LANE_OUT_EN
        if (sq.size() != 0 && sq[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL sqr_missed cyc=%0d required beat at cyc %0d", cyc, sq[0].due);
            void'(sq.pop_front());
        end
        if (bus.o_sqr_valid === 1'b1) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL sqr_unexpected cyc=%0d got %h", cyc, bus.o_sqr);
            end else begin
                s = sq.pop_front();
                if (bus.o_sqr !== s.val || cyc != s.due) begin
                    errors++;
                    $display("FAIL sqr_lanes got %h at cyc %0d required %h at cyc %0d",
                             bus.o_sqr, cyc, s.val, s.due);
                end
            end
        end
`endif
    end

    // one cycle of stimulus on the main instance plus the reference model
    task automatic drive(input int v, input bit vld, input bit clr, input bit rs);
        logic [W-1:0] vb;
        exp_t keep[$];
        sq_t  keep_s[$];
        exp_t ne;
        sq_t  ns;
        longint sum;
        @(posedge clk);
        #1;
        vb = W'(v);
        rst = rs;
        bus.i_valid = vld;
        bus.i_clear = clr;
        for (int k = 0; k < L; k++) bus.i_data[k*W +: W] = vb;
        if (rs || clr) begin
            foreach (eq[i]) if (eq[i].due <= cyc) keep.push_back(eq[i]);
            eq = keep;
            foreach (sq[i]) if (sq[i].due <= cyc) keep_s.push_back(sq[i]);
            sq = keep_s;
            mcnt = 0;
            macc = 0;
        end
        if (!rs && vld) begin
            sum = longint'(L) * v * v;
`ifdef FAST_SQR_LANE_OUT_EN
            for (int k = 0; k < L; k++) ns.val[k*SQ_W +: SQ_W] = SQ_W'(v * v);
            ns.due = cyc + 2;
            sq.push_back(ns);
`endif
            if (mcnt == WIN - 1) begin
                ne.val = macc + sum;
                ne.due = cyc + 4;
                eq.push_back(ne);
                macc = 0;
                mcnt = 0;
            end else begin
                macc = macc + sum;
                mcnt++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.o_energy !== '0 || bus.o_energy_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_energy got %0d/v%b required 0/v0",
                     bus.o_energy, bus.o_energy_valid);
        end
        checks++;
        if (bus2.o_energy !== '0 || bus2.o_energy_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_energy2 got %0d/v%b required 0/v0",
                     bus2.o_energy, bus2.o_energy_valid);
        end
`ifdef FAST_SQR_LANE_OUT_EN
        checks++;
        if (bus.o_sqr !== '0 || bus.o_sqr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_sqr got %h/v%b required 0/v0", bus.o_sqr, bus.o_sqr_valid);
        end
`endif
        idle(2);
    endtask

    task automatic test_max_neg();
        for (int i = 0; i < 16; i++) drive(-256, 1'b1, 1'b0, 1'b0);
        idle(8);
    endtask

    task automatic test_lanes();
        int lv[4];
        lv = '{1, -1, 0, -128};
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b1;
        for (int k = 0; k < L; k++) bus2.i_data[k*W +: W] = W'(lv[k]);
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b0;
        bus2.i_data  = '0;
        @(posedge clk);
        @(negedge clk);
`ifdef FAST_SQR_LANE_OUT_EN
        checks++;
        if (bus2.o_sqr_valid !== 1'b1 ||
            bus2.o_sqr !== {SQ_W'(16384), SQ_W'(0), SQ_W'(1), SQ_W'(1)}) begin
            errors++;
            $display("FAIL lanes_sqr got %h/v%b required lanes 1,1,0,16384",
                     bus2.o_sqr, bus2.o_sqr_valid);
        end
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus2.o_energy_valid !== 1'b1 || bus2.o_energy !== EN2_W'(16386)) begin
            errors++;
            $display("FAIL lanes_energy got %0d/v%b required 16386/v1",
                     bus2.o_energy, bus2.o_energy_valid);
        end
        @(negedge clk);
        checks++;
        if (bus2.o_energy_valid !== 1'b0 || bus2.o_energy !== EN2_W'(16386)) begin
            errors++;
            $display("FAIL lanes_hold got %0d/v%b required 16386/v0",
                     bus2.o_energy, bus2.o_energy_valid);
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 16; i++) begin
            drive(3, 1'b1, 1'b0, 1'b0);
            drive(0, 1'b0, 1'b0, 1'b0);
        end
        idle(8);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10; i++) drive(5, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) drive(2, 1'b1, 1'b0, 1'b0);
        idle(8);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive(1, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.o_energy !== '0 || bus.o_energy_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %0d/v%b required 0/v0",
                     bus.o_energy, bus.o_energy_valid);
        end
`ifdef FAST_SQR_LANE_OUT_EN
        checks++;
        if (bus.o_sqr !== '0 || bus.o_sqr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sqr got %h/v%b required 0/v0",
                     bus.o_sqr, bus.o_sqr_valid);
        end
`endif
        for (int i = 0; i < 16; i++) drive(1, 1'b1, 1'b0, 1'b0);
        idle(8);
    endtask

    task automatic test_clear_valid();
        for (int i = 0; i < 3; i++) drive(7, 1'b1, 1'b0, 1'b0);
        drive(4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) drive(4, 1'b1, 1'b0, 1'b0);
        idle(8);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) drive(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(2, 1'b1, 1'b0, 1'b0);
        idle(8);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        cyc = 0;
        errors = 0;
        checks = 0;
        hold = 0;
        mcnt = 0;
        macc = 0;
        bus.i_valid  = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_data   = '0;
        bus2.i_valid = 1'b0;
        bus2.i_clear = 1'b0;
        bus2.i_data  = '0;
        test_reset();
        test_max_neg();
        test_lanes();
        test_bubbles();
        test_clear();
        test_reset_mid();
        test_clear_valid();
        test_back_to_back();
        @(negedge clk);
        checks++;
        if (eq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending required 0/0", eq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
